// File: rtl/obuf_port_arb_pkg.sv
// Shared router definitions: port count, flit width and arbiter state encoding.
package obuf_port_arb_pkg;

    localparam int N_PORTS    = 4;
    localparam int PYLD_W_DEF = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Width of an index over n ports; never below one bit so n=1 still has a field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obuf_port_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module obuf_port_arb_rr_pick
    import obuf_port_arb_pkg::*;
#(
    parameter int N     = N_PORTS,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan ptr, ptr+1, ... modulo N and latch onto the first active request.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/obuf_port_arb.sv
// Output-port arbiter: round-robin with per-packet lock feeding a one-entry
// valid/ready output slot that can refill on the cycle it drains.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no packet open; round-robin winner from ptr is offered the slot
// ST_LOCKED | owner is mid-packet; only owner may transfer until its tail
module obuf_port_arb
    import obuf_port_arb_pkg::*;
#(
    parameter int N_REQ  = N_PORTS,
    parameter int PYLD_W = PYLD_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    input  logic [N_REQ*PYLD_W-1:0] req_payload_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [PYLD_W-1:0]       payload_o,
    input  logic                    ready_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e         state, state_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [N_REQ-1:0]   grant_next;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               slot_acc;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               sel_last;
    logic [PYLD_W-1:0]  sel_payload;
    logic [IDX_W-1:0]   sel_idx_inc;
    logic               xfer;

    obuf_port_arb_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_valid_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign slot_acc = ~valid_o | ready_i;
    assign busy_o   = (state == ST_LOCKED);

    // Select the active requester and mux only its fields so unselected X cannot leak.
    always_comb begin
        sel_idx     = (state == ST_LOCKED) ? owner : pick_idx;
        sel_valid   = (state == ST_LOCKED) ? req_valid_i[owner] : pick_any;
        sel_last    = req_last_i[sel_idx];
        sel_payload = req_payload_i[int'(sel_idx) * PYLD_W +: PYLD_W];
        sel_idx_inc = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
        xfer        = slot_acc & sel_valid;
    end

    // Accept strobes: the round-robin winner when idle, only the owner when locked.
    always_comb begin
        req_ready_o = '0;
        if (state == ST_IDLE) begin
            req_ready_o = pick_gnt & {N_REQ{slot_acc}};
        end else begin
            req_ready_o[owner] = slot_acc;
        end
    end

    // Next-state: open a lock on a non-tail head, release and advance ptr on a tail.
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        grant_next = grant_o;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_next = sel_idx_inc;
                    end else begin
                        state_next = ST_LOCKED;
                        owner_next = sel_idx;
                        grant_next = pick_gnt;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_next = ST_IDLE;
                    ptr_next   = sel_idx_inc;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= '0;
            ptr     <= '0;
            grant_o <= '0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            ptr     <= ptr_next;
            grant_o <= grant_next;
        end
    end

    // Output slot: load on transfer, empty on drain without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            payload_o <= '0;
        end else if (xfer) begin
            valid_o   <= 1'b1;
            last_o    <= sel_last;
            payload_o <= sel_payload;
        end else if (ready_i) begin
            valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obuf_port_arb.sv
// Directed bench for obuf_port_arb (N_REQ=4, PYLD_W=32).
module tb_obuf_port_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_last_i;
    logic [N*W-1:0] req_payload_i;
    logic [N-1:0]   req_ready_o;
    logic           valid_o;
    logic           last_o;
    logic [W-1:0]   payload_o;
    logic           ready_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    obuf_port_arb #(.N_REQ(N), .PYLD_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_last_i    (req_last_i),
        .req_payload_i (req_payload_i),
        .req_ready_o   (req_ready_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .payload_o     (payload_o),
        .ready_i       (ready_i),
        .grant_o       (grant_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int i, input logic [W-1:0] v);
        req_payload_i[i*W +: W] = v;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid_i   = '0;
        req_last_i    = '0;
        req_payload_i = '0;
        ready_i       = 1'b0;
        #12;
        chk("rst_valid",   32'(valid_o),   32'h0);
        chk("rst_last",    32'(last_o),    32'h0);
        chk("rst_payload", payload_o,      32'h0);
        chk("rst_grant",   32'(grant_o),   32'h0);
        chk("rst_busy",    32'(busy_o),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single-flit packets from 0 and 2
        ready_i     = 1'b1;
        req_valid_i = 4'b0101;
        req_last_i  = 4'b0101;
        set_pl(0, 32'hA0);
        set_pl(2, 32'hA2);
        #1;
        chk("t1_rdy0", 32'(req_ready_o), 32'b0001);
        tick();
        req_valid_i = 4'b0100;
        #1;
        chk("t1_pl0",   payload_o,         32'hA0);
        chk("t1_vld0",  32'(valid_o),      32'h1);
        chk("t1_rdy2",  32'(req_ready_o),  32'b0100);
        tick();
        req_valid_i = 4'b0000;
        #1;
        chk("t1_pl2",   payload_o,         32'hA2);
        chk("t1_busy",  32'(busy_o),       32'h0);
        tick();
        chk("t1_drain", 32'(valid_o),      32'h0);
        // ptr must now be 3: with 1 and 3 valid, 3 is offered
        ready_i     = 1'b0;
        req_valid_i = 4'b1010;
        req_last_i  = 4'b1000;
        #1;
        chk("t1_ptr3",  32'(req_ready_o),  32'b1000);

        // 3-flit packet from 1 while 3 waits
        req_valid_i = 4'b0010;
        ready_i     = 1'b1;
        set_pl(1, 32'h11);
        #1;
        chk("t2_rdy_h", 32'(req_ready_o),  32'b0010);
        tick();
        req_valid_i = 4'b1010;
        set_pl(1, 32'h12);
        set_pl(3, 32'h33);
        #1;
        chk("t2_pl11",  payload_o,         32'h11);
        chk("t2_gnt_a", 32'(grant_o),      32'b0010);
        chk("t2_busy",  32'(busy_o),       32'h1);
        chk("t2_rdy_a", 32'(req_ready_o),  32'b0010);
        tick();
        set_pl(1, 32'h13);
        req_last_i = 4'b1010;
        #1;
        chk("t2_pl12",  payload_o,         32'h12);
        chk("t2_gnt_b", 32'(grant_o),      32'b0010);
        chk("t2_rdy_b", 32'(req_ready_o),  32'b0010);
        tick();
        req_valid_i = 4'b1000;
        #1;
        chk("t2_pl13",  payload_o,         32'h13);
        chk("t2_last",  32'(last_o),       32'h1);
        chk("t2_gnt_c", 32'(grant_o),      32'b0000);
        chk("t2_idle",  32'(busy_o),       32'h0);
        chk("t2_rdy3",  32'(req_ready_o),  32'b1000);
        tick();
        req_valid_i = 4'b0000;
        #1;
        chk("t2_pl33",  payload_o,         32'h33);
        tick();

        // backpressure with slot full
        ready_i     = 1'b0;
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0001;
        set_pl(0, 32'hB0);
        tick();
        set_pl(0, 32'hB1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_hold_v",   32'(valid_o),     32'h1);
            chk("t3_hold_pl",  payload_o,        32'hB0);
            chk("t3_hold_rdy", 32'(req_ready_o), 32'b0000);
            tick();
        end
        ready_i = 1'b1;
        #1;
        chk("t3_rdy_rel", 32'(req_ready_o), 32'b0001);
        tick();
        req_valid_i = 4'b0000;
        #1;
        chk("t3_nobub_v",  32'(valid_o), 32'h1);
        chk("t3_nobub_pl", payload_o,    32'hB1);
        tick();
        chk("t3_drain", 32'(valid_o), 32'h0);

        // owner 1 stalls mid-packet while 0 waits
        req_valid_i = 4'b0010;
        req_last_i  = 4'b0000;
        set_pl(1, 32'hC1);
        tick();
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0011;
        set_pl(0, 32'hD0);
        #1;
        chk("t4_pl_c1",  payload_o,        32'hC1);
        chk("t4_gnt",    32'(grant_o),     32'b0010);
        chk("t4_rdy",    32'(req_ready_o), 32'b0010);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_gap_v",   32'(valid_o),     32'h0);
            chk("t4_gap_bsy", 32'(busy_o),      32'h1);
            chk("t4_gap_rdy", 32'(req_ready_o), 32'b0010);
        end
        req_valid_i = 4'b0011;
        set_pl(1, 32'hC2);
        tick();
        req_valid_i = 4'b0001;
        #1;
        chk("t4_pl_c2", payload_o,        32'hC2);
        chk("t4_idle",  32'(busy_o),      32'h0);
        chk("t4_rdy0",  32'(req_ready_o), 32'b0001);
        tick();
        req_valid_i = 4'b1000;
        req_last_i  = 4'b1000;
        set_pl(3, 32'h3F);
        #1;
        chk("t4_pl_d0", payload_o,        32'hD0);
        chk("t4_rdy3",  32'(req_ready_o), 32'b1000);
        tick();

        // full load rotation starting at ptr 0
        req_valid_i = 4'b1111;
        req_last_i  = 4'b1111;
        for (int i = 0; i < N; i++) set_pl(i, 32'hE0 + 32'(i));
        #1;
        chk("t5_pl_3f", payload_o, 32'h3F);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t5_rdy", 32'(req_ready_o), 32'(1 << (i % 4)));
            tick();
            chk("t5_pl", payload_o, 32'hE0 + 32'(i % 4));
        end
        req_valid_i = 4'b0000;
        tick();

        // reset while requester 2 holds the lock
        req_valid_i = 4'b0100;
        req_last_i  = 4'b0000;
        set_pl(2, 32'hF2);
        tick();
        chk("t6_gnt",  32'(grant_o), 32'b0100);
        chk("t6_busy", 32'(busy_o),  32'h1);
        req_valid_i = 4'b0101;
        req_last_i  = 4'b0001;
        set_pl(0, 32'hF0);
        set_pl(2, 32'hF3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v",    32'(valid_o), 32'h0);
        chk("t6_rst_gnt",  32'(grant_o), 32'h0);
        chk("t6_rst_busy", 32'(busy_o),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_rdy0", 32'(req_ready_o), 32'b0001);
        tick();
        chk("t6_pl_f0", payload_o,       32'hF0);
        chk("t6_busy2", 32'(busy_o),     32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
